sram_bank: RTL and testbench
============================

# sram_bank

Parametrised synchronous byte-lane SRAM model for the RISC-V core's external data-memory port. It replaces the fixed 16-bit, combinational-read model with configurable lane count, lane width, depth and read latency, and adds a pipelined read-valid strobe. An optional post-reset clear sequencer zeroes the array and gates all accesses until it finishes. It sits under the top level, driven directly by the core's active-low SRAM pins.

## Interface
- BYTE_WIDTH, 8: bits per lane.
- BYTES, 2: lanes per word. Word width DW = BYTES*BYTE_WIDTH.
- ADDRESS_WIDTH, 12: word-address bits. Depth = 2**ADDRESS_WIDTH.
- READ_LATENCY, 1: edges from read sample to data valid. Legal values 1..4; other values are a elaboration error.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = contents untouched by reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- sram_addr  in  ADDRESS_WIDTH  word address.
- sram_d  in  DW  write data.
- sram_q  out  DW  read data.
- sram_ce_n  in  1  chip enable, active low.
- sram_we_n  in  1  write enable, active low.
- sram_oe_n  in  1  output enable, active low.
- sram_be_n  in  BYTES  lane enables, active low. Bit i controls bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- q_vld  out  1  sram_q carries the result of a read this cycle.
- ready  out  1  array is accepting accesses.

## Operation
- FSM states: CLEAR and IDLE.
- Reset asserted (sampled at an edge):
  - Next state is CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - Clear counter = 0.
  - Read pipeline flushed: all stage valids = 0, sram_q = 0, q_vld = 0.
- CLEAR state:
  - ready = 0.
  - Each cycle, writes 0 to word[counter] on all lanes, then counter increments.
  - The edge that clears word 2**ADDRESS_WIDTH-1 moves the FSM to IDLE.
  - All pin requests are ignored: no write, no read, no q_vld.
- IDLE state: ready = 1. A request is accepted when sram_ce_n=0.
  - Write: sram_we_n=0. Each lane with sram_be_n[i]=0 stores its slice of sram_d at the edge. Other lanes are unchanged. sram_oe_n is ignored.
  - Read: sram_we_n=1 and sram_oe_n=0.
    - The word is sampled at the edge into pipeline stage 1.
    - Lanes with sram_be_n[i]=1 are forced to 0 in the captured value.
    - The value then advances one stage per edge.
  - No operation when sram_ce_n=1, or when sram_we_n=1 and sram_oe_n=1.
- The read pipeline is READ_LATENCY stages, each with its own valid bit.
  - sram_q and q_vld are driven from the last stage.
  - When the last stage is invalid, sram_q holds its previous value and q_vld = 0.
- Back-to-back reads are accepted every cycle. Throughput is one word per cycle and there is no backpressure.
- Read data is captured at issue. A write to the same address on a later cycle, while the read is in flight, does not alter the returned value.
- A write at edge k followed by a read sampled at edge k+1 to the same address returns the new data.
- Reset during CLEAR restarts the clear from word 0.
- Reset with reads in flight discards them: no q_vld is produced for them.
- Address wraps modulo depth by construction; there are no out-of-range accesses.

## Timing
- Reset values: sram_q = 0, q_vld = 0, ready = 0 when CLEAR_ON_RESET=1, and ready = 1 otherwise.
- Clear duration: 2**ADDRESS_WIDTH cycles after the reset-release edge. ready rises after the edge that clears the last word.
- Read sampled at edge k: sram_q and q_vld = 1 are valid after edge k+READ_LATENCY-1. For READ_LATENCY=1 they appear right after the sampling edge.
- q_vld is high for exactly one cycle per accepted read.
- Writes commit at the sampling edge. There is no write-to-output path.
- All outputs are registered. There is no combinational path from inputs to sram_q, q_vld or ready.

## Test plan
- Clear sequence, with ADDRESS_WIDTH=4 and CLEAR_ON_RESET=1:
  - Preload word 5 = 16'hBEEF, then pulse reset.
  - ready must stay 0 for 16 cycles, then rise.
  - A read of word 5 must then return 16'h0000.
- Byte-lane writes, with defaults:
  - Write 16'h1234 to address 3 with be_n=2'b00, then 16'hAB00 with be_n=2'b01.
  - Read address 3 must give 16'hAB34.
  - A read with be_n=2'b10 must give 16'h0034.
- Latency sweep, with READ_LATENCY=3:
  - Reads of addresses 0,1,2 on consecutive cycles, preloaded with 16'h1111, 16'h2222, 16'h3333.
  - q_vld must be high on three consecutive cycles, starting 2 cycles after the first sampling edge, with the data in order.
- Write after read in flight, with READ_LATENCY=4:
  - Read address 7 (holding 16'h00AA), then write 16'h5555 to address 7 on the next cycle.
  - The returned data must be 16'h00AA.
  - A subsequent read must return 16'h5555.
- Reset mid-operation:
  - Assert reset with 2 reads in flight and the clear counter at 9.
  - No q_vld may be produced for those reads.
  - sram_q must be 0 and ready must be 0, and the clear must restart at word 0, taking the full 2**ADDRESS_WIDTH cycles.
- Idle and ignored requests:
  - sram_ce_n=1 with we_n=0 must not modify the array.
  - ce_n=0 with we_n=1 and oe_n=1 must produce no q_vld.
  - Requests made during CLEAR must be ignored.

Source files
------------

// File: rtl/sram_bank.sv
// sram_bank: parametrised synchronous byte-lane SRAM with pipelined reads.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   sram_addr       word address (wraps modulo depth)
//   sram_d          write data, DW = BYTES*BYTE_WIDTH bits
//   sram_q          registered read data from the last pipeline stage
//   sram_ce_n       chip enable, active low
//   sram_we_n       write enable, active low
//   sram_oe_n       output enable, active low
//   sram_be_n       per-lane enables, active low
//   q_vld           one-cycle strobe per returned read
//   ready           array accepts requests (low while clearing)

module sram_bank #(
    parameter int BYTE_WIDTH     = 8,
    parameter int BYTES          = 2,
    parameter int ADDRESS_WIDTH  = 12,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDRESS_WIDTH-1:0]      sram_addr,
    input  logic [BYTES*BYTE_WIDTH-1:0]   sram_d,
    output logic [BYTES*BYTE_WIDTH-1:0]   sram_q,
    input  logic                          sram_ce_n,
    input  logic                          sram_we_n,
    input  logic                          sram_oe_n,
    input  logic [BYTES-1:0]              sram_be_n,
    output logic                          q_vld,
    output logic                          ready
);

    localparam int DW    = BYTES * BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("sram_bank: READ_LATENCY must be in 1..4");
        end
    endgenerate

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                       state;
    logic [ADDRESS_WIDTH-1:0]     clear_cnt;

    logic [BYTES-1:0][BYTE_WIDTH-1:0] mem [DEPTH];

    logic                         accept;
    logic                         wr_en;
    logic                         rd_en;
    logic [DW-1:0]                rd_word;

    logic [READ_LATENCY-1:0]          pipe_v;
    logic [READ_LATENCY-1:0][DW-1:0]  pipe_q;

    // Requests are only honoured in IDLE and never on a reset edge.
    assign accept = (state == IDLE) && !reset && !sram_ce_n;

    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (accept) begin
            if (!sram_we_n) begin
                wr_en = 1'b1;
            end else if (!sram_oe_n) begin
                rd_en = 1'b1;
            end
        end
    end

    // Disabled lanes read back as zero in the captured word.
    always_comb begin
        rd_word = mem[sram_addr];
        for (int i = 0; i < BYTES; i++) begin
            if (sram_be_n[i]) begin
                rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = '0;
            end
        end
    end

    // Clear sequencer; ready is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clear_cnt <= '0;
            ready     <= (CLEAR_ON_RESET == 0);
        end else begin
            case (state)
                CLEAR: begin
                    clear_cnt <= clear_cnt + 1'b1;
                    if (clear_cnt == '1) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                IDLE: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Array: zero-fill while clearing, otherwise lane-masked writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clear_cnt] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (!sram_be_n[i]) begin
                        mem[sram_addr][i] <=
                            sram_d[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Read pipeline: data registers only load behind a valid stage,
    // so the last stage holds its value while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v <= '0;
            pipe_q <= '0;
        end else begin
            pipe_v[0] <= rd_en;
            if (rd_en) begin
                pipe_q[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end
    end

    assign sram_q = pipe_q[READ_LATENCY-1];
    assign q_vld  = pipe_v[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank: directed and random checks of sram_bank against
// a queue-based reference model (depth 16, read latency 3).

module tb_sram_bank;

    localparam int BW    = 8;
    localparam int NB    = 2;
    localparam int AW    = 4;
    localparam int RL    = 3;
    localparam int DW    = BW * NB;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] d = '0;
    logic [DW-1:0] q;
    logic          ce_n = 1'b1;
    logic          we_n = 1'b1;
    logic          oe_n = 1'b1;
    logic [NB-1:0] be_n = '1;
    logic          q_vld;
    logic          ready;

    always #5 clk = ~clk;

    sram_bank #(
        .BYTE_WIDTH(BW),
        .BYTES(NB),
        .ADDRESS_WIDTH(AW),
        .READ_LATENCY(RL),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sram_addr(addr),
        .sram_d(d),
        .sram_q(q),
        .sram_ce_n(ce_n),
        .sram_we_n(we_n),
        .sram_oe_n(oe_n),
        .sram_be_n(be_n),
        .q_vld(q_vld),
        .ready(ready)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] m_mem [DEPTH];
    rd_t           pend[$];
    int            cyc = 0;
    bit            m_clear = 1'b0;
    int            m_cnt = 0;
    logic [DW-1:0] m_q = '0;
    bit            m_vld = 1'b0;
    bit            m_ready = 1'b0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_mask(logic [NB-1:0] ben);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++)
            if (!ben[i]) m = m | (DW'(8'hFF) << (BW * i));
        return m;
    endfunction

    // Reference behaviour for one rising edge, using the pins as driven.
    task automatic model_edge();
        logic [DW-1:0] mk;
        cyc++;
        m_vld = 1'b0;
        if (reset) begin
            m_clear = 1'b1;
            m_cnt = 0;
            pend.delete();
            m_q = '0;
            m_ready = 1'b0;
            return;
        end
        if (m_clear) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_clear = 1'b0;
                m_ready = 1'b1;
            end
        end else if (!ce_n && !we_n) begin
            mk = lane_mask(be_n);
            m_mem[addr] = (m_mem[addr] & ~mk) | (d & mk);
        end else if (!ce_n && !oe_n) begin
            pend.push_back('{cyc + RL - 1, m_mem[addr] & lane_mask(be_n)});
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            m_vld = 1'b1;
            m_q = pend[0].data;
            void'(pend.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("q_vld", q_vld, m_vld);
        check("sram_q", q, m_q);
        check("ready", ready, m_ready);
    endtask

    task automatic set_idle();
        ce_n = 1'b1;
        we_n = 1'b1;
        oe_n = 1'b1;
        be_n = '1;
    endtask

    task automatic wr(logic [AW-1:0] a, logic [DW-1:0] v, logic [NB-1:0] b);
        ce_n = 1'b0;
        we_n = 1'b0;
        oe_n = 1'b1;
        be_n = b;
        addr = a;
        d = v;
        tick();
        set_idle();
    endtask

    task automatic rd(logic [AW-1:0] a, logic [NB-1:0] b);
        ce_n = 1'b0;
        we_n = 1'b1;
        oe_n = 1'b0;
        be_n = b;
        addr = a;
        tick();
        set_idle();
    endtask

    task automatic wait_vld(string tag, logic [DW-1:0] exp);
        for (int i = 0; i < 8; i++) begin
            if (q_vld) break;
            tick();
        end
        check({tag, "_vld"}, q_vld, 1'b1);
        check(tag, q, exp);
    endtask

    task automatic rd_expect(string tag, logic [AW-1:0] a,
                             logic [NB-1:0] b, logic [DW-1:0] exp);
        rd(a, b);
        wait_vld(tag, exp);
    endtask

    // Counts edges until ready rises, applying the given request pins.
    task automatic wait_ready(output int n, output bit saw_vld,
                              input bit poke);
        n = 0;
        saw_vld = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (poke) begin
                ce_n = 1'b0;
                we_n = i[0];
                oe_n = 1'b0;
                be_n = '0;
                addr = 4'd5;
                d = 16'hFFFF;
            end
            tick();
            n++;
            if (q_vld) saw_vld = 1'b1;
            if (ready) break;
        end
        set_idle();
    endtask

    initial begin : main
        int  n;
        bit  sv;

        // Reset state and first clear, with requests poked during it.
        set_idle();
        reset = 1'b1;
        tick();
        check("rst_q", q, 16'h0000);
        check("rst_vld", q_vld, 1'b0);
        check("rst_ready", ready, 1'b0);
        reset = 1'b0;
        wait_ready(n, sv, 1'b1);
        check("clear_len0", n, 16);
        check("clear_vld0", sv, 1'b0);
        rd_expect("clear_ign", 4'd5, 2'b00, 16'h0000);

        // Clear after preload.
        wr(4'd5, 16'hBEEF, 2'b00);
        rd_expect("preload", 4'd5, 2'b00, 16'hBEEF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready(n, sv, 1'b0);
        check("clear_len1", n, 16);
        rd_expect("cleared5", 4'd5, 2'b00, 16'h0000);

        // Byte lanes.
        wr(4'd3, 16'h1234, 2'b00);
        wr(4'd3, 16'hAB00, 2'b01);
        rd_expect("lane_full", 4'd3, 2'b00, 16'hAB34);
        rd_expect("lane_lo", 4'd3, 2'b10, 16'h0034);

        // Back-to-back reads through the 3-stage pipeline.
        wr(4'd0, 16'h1111, 2'b00);
        wr(4'd1, 16'h2222, 2'b00);
        wr(4'd2, 16'h3333, 2'b00);
        rd(4'd0, 2'b00);
        check("lat_k0", q_vld, 1'b0);
        rd(4'd1, 2'b00);
        check("lat_k1", q_vld, 1'b0);
        rd(4'd2, 2'b00);
        check("lat_k2_vld", q_vld, 1'b1);
        check("lat_k2_q", q, 16'h1111);
        tick();
        check("lat_k3_vld", q_vld, 1'b1);
        check("lat_k3_q", q, 16'h2222);
        tick();
        check("lat_k4_vld", q_vld, 1'b1);
        check("lat_k4_q", q, 16'h3333);
        tick();
        check("lat_k5_vld", q_vld, 1'b0);
        check("lat_hold", q, 16'h3333);

        // Write to an address whose read is still in flight.
        wr(4'd7, 16'h00AA, 2'b00);
        rd(4'd7, 2'b00);
        wr(4'd7, 16'h5555, 2'b00);
        wait_vld("war_old", 16'h00AA);
        rd_expect("war_new", 4'd7, 2'b00, 16'h5555);

        // Read right after write.
        wr(4'd9, 16'hC0DE, 2'b00);
        rd_expect("raw", 4'd9, 2'b00, 16'hC0DE);

        // Ignored requests.
        ce_n = 1'b1;
        we_n = 1'b0;
        be_n = '0;
        addr = 4'd7;
        d = 16'h0000;
        tick();
        set_idle();
        rd_expect("ce_off_wr", 4'd7, 2'b00, 16'h5555);
        sv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ce_n = 1'b0;
            addr = 4'd7;
            tick();
            if (q_vld) sv = 1'b1;
        end
        set_idle();
        check("nop_vld", sv, 1'b0);

        // Reset with two reads in flight.
        rd(4'd7, 2'b00);
        rd(4'd9, 2'b00);
        reset = 1'b1;
        tick();
        check("mid_rst_q", q, 16'h0000);
        check("mid_rst_vld", q_vld, 1'b0);
        check("mid_rst_ready", ready, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid_clr_busy", ready, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready(n, sv, 1'b0);
        check("restart_len", n, 16);
        check("flush_vld", sv, 1'b0);
        rd_expect("restart_zero", 4'd9, 2'b00, 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            ce_n = ($urandom_range(0, 3) == 0);
            we_n = ($urandom_range(0, 2) != 0);
            oe_n = ($urandom_range(0, 4) == 0);
            be_n = NB'($urandom);
            addr = AW'($urandom);
            d = DW'($urandom);
            tick();
        end
        reset = 1'b0;
        set_idle();
        for (int i = 0; i < 24; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
